// File: rtl/read_reorder_buffer.sv
// read_reorder_buffer: in-order return buffer for out-of-order DRAM read data.
// A slot is allocated at the tail for every outstanding read. Fills may arrive
// in any order. Lines leave from the head strictly in allocation order.
// Ports:
//   clk, reset (async, active-low)
//   alloc_req/alloc_gnt/alloc_id  : slot allocation (tail)
//   fill_en/fill_id/fill_data     : DRAM return data
//   out_valid/out_ready/out_data/out_id : in-order head line
//   count/full/empty              : occupancy
//   fill_err                      : sticky illegal-fill flag
module read_reorder_buffer #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned BUFFER_SIZE = 128,
  localparam int unsigned ID_WIDTH   = $clog2(BUFFER_SIZE),
  localparam int unsigned PTR_WIDTH  = ID_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [ID_WIDTH-1:0]   alloc_id,
  input  logic                  fill_en,
  input  logic [ID_WIDTH-1:0]   fill_id,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [ID_WIDTH:0]     count,
  output logic                  full,
  output logic                  empty,
  output logic                  fill_err
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_WIDTH-1:0]   head;
  logic [PTR_WIDTH-1:0]   tail;
  logic [BUFFER_SIZE-1:0] filled;
  logic [BUFFER_SIZE-1:0] filled_next;
  logic [DATA_WIDTH-1:0]  mem [BUFFER_SIZE];

  logic [ID_WIDTH-1:0] head_slot;
  logic [ID_WIDTH-1:0] fill_off;
  logic                fill_legal;
  logic                pop;

  // Occupancy and status.
  assign head_slot = head[ID_WIDTH-1:0];
  assign count     = tail - head;
  assign full      = (count == PTR_WIDTH'(BUFFER_SIZE));
  assign empty     = (count == '0);

  // Allocation handshake.
  assign alloc_gnt = alloc_req && !full;
  assign alloc_id  = tail[ID_WIDTH-1:0];

  // Head presentation straight from registered state.
  assign out_valid = !empty && filled[head_slot];
  assign out_data  = mem[head_slot];
  assign out_id    = head_slot;
  assign pop       = out_valid && out_ready;

  // Fill is legal when its distance from head is inside the allocated window
  // and the slot has not already been written.
  assign fill_off   = fill_id - head_slot;
  assign fill_legal = fill_en && ({1'b0, fill_off} < count) && !filled[fill_id];

  // Filled-bit update; a pop and a legal fill never target the same slot
  // because a popped head is already filled.
  always_comb begin
    filled_next = filled;
    if (pop) begin
      filled_next[head_slot] = 1'b0;
    end
    if (fill_legal) begin
      filled_next[fill_id] = 1'b1;
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      filled   <= '0;
      fill_err <= 1'b0;
    end else begin
      if (alloc_gnt) begin
        tail <= tail + PTR_WIDTH'(1);
      end
      if (pop) begin
        head <= head + PTR_WIDTH'(1);
      end
      filled <= filled_next;
      if (fill_en && !fill_legal) begin
        fill_err <= 1'b1;
      end
    end
  end

  // Line storage; contents are meaningless until the slot's filled bit is set.
  always_ff @(posedge clk) begin
    if (fill_legal) begin
      mem[fill_id] <= fill_data;
    end
  end

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Bench for read_reorder_buffer: small instance (4 x 8b) for directed cases and a
// default-size instance for a random-order wrap-around run. Expected lines are
// queued at stimulus time and compared by per-instance monitors on each pop.
module tb_read_reorder_buffer;
  localparam int unsigned DW  = 8;
  localparam int unsigned BS  = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned RDW = 512;
  localparam int unsigned RBS = 128;
  localparam int unsigned RIW = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          d_alloc_req, d_alloc_gnt, d_fill_en, d_out_valid, d_out_ready;
  logic [IW-1:0] d_alloc_id, d_fill_id, d_out_id;
  logic [DW-1:0] d_fill_data, d_out_data;
  logic [IW:0]   d_count;
  logic          d_full, d_empty, d_fill_err;

  logic           r_alloc_req, r_alloc_gnt, r_fill_en, r_out_valid, r_out_ready;
  logic [RIW-1:0] r_alloc_id, r_fill_id, r_out_id;
  logic [RDW-1:0] r_fill_data, r_out_data;
  logic [RIW:0]   r_count;
  logic           r_full, r_empty, r_fill_err;

  read_reorder_buffer #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .reset(reset),
    .alloc_req(d_alloc_req), .alloc_gnt(d_alloc_gnt), .alloc_id(d_alloc_id),
    .fill_en(d_fill_en), .fill_id(d_fill_id), .fill_data(d_fill_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_id(d_out_id),
    .count(d_count), .full(d_full), .empty(d_empty), .fill_err(d_fill_err)
  );

  read_reorder_buffer dut2 (
    .clk(clk), .reset(reset),
    .alloc_req(r_alloc_req), .alloc_gnt(r_alloc_gnt), .alloc_id(r_alloc_id),
    .fill_en(r_fill_en), .fill_id(r_fill_id), .fill_data(r_fill_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data), .out_id(r_out_id),
    .count(r_count), .full(r_full), .empty(r_empty), .fill_err(r_fill_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t           sb[$];
  int             sb2[$];
  logic [RDW-1:0] mem2 [RBS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    d_alloc_req = 1'b0;
    d_fill_en   = 1'b0;
    d_fill_id   = '0;
    d_fill_data = '0;
    d_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic fill(input int id, input logic [DW-1:0] data);
    d_fill_en   = 1'b1;
    d_fill_id   = IW'(id);
    d_fill_data = data;
  endtask

  task automatic alloc_n(input int n);
    d_alloc_req = 1'b1;
    repeat (n) step();
    d_alloc_req = 1'b0;
  endtask

  function automatic logic [RDW-1:0] rand_line();
    logic [RDW-1:0] v;
    for (int w = 0; w < RDW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Small-instance monitor: every pop must match the next expected line.
  always @(negedge clk) begin
    exp_t e;
    if (reset && d_out_valid && d_out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got id=%0d data=%h, required no pop", d_out_id, d_out_data);
      end else begin
        e = sb.pop_front();
        if (d_out_id !== IW'(e.id) || d_out_data !== e.data) begin
          n_bad++;
          $display("FAIL pop_order: got id=%0d data=%h, required id=%0d data=%h",
                   d_out_id, d_out_data, e.id, e.data);
        end
      end
    end
  end

  // Default-size monitor: ids in allocation order, data as last filled.
  always @(negedge clk) begin
    int id;
    if (reset && r_out_valid && r_out_ready) begin
      n_vec++;
      if (sb2.size() == 0) begin
        n_bad++;
        $display("FAIL rand_pop_unexpected: got id=%0d, required no pop", r_out_id);
      end else begin
        id = sb2.pop_front();
        if (r_out_id !== RIW'(id) || r_out_data !== mem2[id]) begin
          n_bad++;
          $display("FAIL rand_pop: got id=%0d data=%h, required id=%0d data=%h",
                   r_out_id, r_out_data, id, mem2[id]);
        end
      end
    end
  end

  initial begin
    int tail2;
    int pend[$];

    reset       = 1'b0;
    r_alloc_req = 1'b0;
    r_fill_en   = 1'b0;
    r_fill_id   = '0;
    r_fill_data = '0;
    r_out_ready = 1'b0;
    idle();
    #12;
    chk("rst_count",     32'(d_count), 32'd0);
    chk("rst_empty",     32'(d_empty), 32'd1);
    chk("rst_full",      32'(d_full), 32'd0);
    chk("rst_out_valid", 32'(d_out_valid), 32'd0);
    chk("rst_alloc_id",  32'(d_alloc_id), 32'd0);
    chk("rst_fill_err",  32'(d_fill_err), 32'd0);
    reset = 1'b1;
    step();

    // Out-of-order return, in-order delivery.
    sb.push_back('{0, 8'hA0});
    sb.push_back('{1, 8'hB1});
    sb.push_back('{2, 8'hC2});
    d_alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ooo_gnt", 32'(d_alloc_gnt), 32'd1);
      chk("ooo_id",  32'(d_alloc_id), 32'(i));
      step();
    end
    d_alloc_req = 1'b0;
    d_out_ready = 1'b1;
    fill(2, 8'hC2); settle(); chk("ooo_hidden_c2", 32'(d_out_valid), 32'd0); step();
    fill(0, 8'hA0); settle(); chk("ooo_no_bypass", 32'(d_out_valid), 32'd0); step();
    fill(1, 8'hB1); settle();
    chk("ooo_valid_a0", 32'(d_out_valid), 32'd1);
    chk("ooo_data_a0",  32'(d_out_data), 32'hA0);
    step();
    d_fill_en = 1'b0;
    settle(); chk("ooo_data_b1", 32'(d_out_data), 32'hB1); step();
    settle(); chk("ooo_data_c2", 32'(d_out_data), 32'hC2); step();
    settle();
    chk("ooo_empty",    32'(d_empty), 32'd1);
    chk("ooo_fill_err", 32'(d_fill_err), 32'd0);
    chk("ooo_drained",  32'(sb.size()), 32'd0);

    // Full, then simultaneous pop and alloc.
    idle(); do_reset(); step();
    d_alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("full_gnt", 32'(d_alloc_gnt), 32'd1);
      chk("full_id",  32'(d_alloc_id), 32'(i));
      step();
    end
    settle();
    chk("full_flag",  32'(d_full), 32'd1);
    chk("full_count", 32'(d_count), 32'd4);
    chk("full_deny",  32'(d_alloc_gnt), 32'd0);
    fill(0, 8'h11);
    step();
    d_fill_en   = 1'b0;
    sb.push_back('{0, 8'h11});
    d_out_ready = 1'b1;
    settle();
    chk("full_pop_deny", 32'(d_alloc_gnt), 32'd0);
    chk("full_pop_valid", 32'(d_out_valid), 32'd1);
    step();
    d_out_ready = 1'b0;
    settle();
    chk("wrap_gnt",   32'(d_alloc_gnt), 32'd1);
    chk("wrap_id",    32'(d_alloc_id), 32'd0);
    chk("wrap_count", 32'(d_count), 32'd3);
    step();
    d_alloc_req = 1'b0;
    settle();
    chk("refull_count", 32'(d_count), 32'd4);

    // Fill outside the allocated window.
    idle(); do_reset(); step();
    alloc_n(2);
    fill(3, 8'h33); settle(); chk("oow_err_before", 32'(d_fill_err), 32'd0); step();
    d_fill_en = 1'b0;
    settle();
    chk("oow_err",   32'(d_fill_err), 32'd1);
    chk("oow_valid", 32'(d_out_valid), 32'd0);
    chk("oow_count", 32'(d_count), 32'd2);

    // Double fill keeps the first line.
    idle(); do_reset(); step();
    alloc_n(1);
    fill(0, 8'hA5); step();
    fill(0, 8'h5A); settle();
    chk("dbl_err_before", 32'(d_fill_err), 32'd0);
    chk("dbl_data_first", 32'(d_out_data), 32'hA5);
    step();
    d_fill_en = 1'b0;
    settle();
    chk("dbl_err",   32'(d_fill_err), 32'd1);
    chk("dbl_data",  32'(d_out_data), 32'hA5);
    chk("dbl_valid", 32'(d_out_valid), 32'd1);
    sb.push_back('{0, 8'hA5});
    d_out_ready = 1'b1;
    step();
    settle();
    chk("dbl_empty", 32'(d_empty), 32'd1);

    // Alloc and fill of the new id in the same cycle while empty.
    idle(); do_reset(); step();
    d_alloc_req = 1'b1;
    fill(0, 8'hEE);
    settle(); chk("same_gnt", 32'(d_alloc_gnt), 32'd1);
    step();
    idle(); settle();
    chk("same_err",   32'(d_fill_err), 32'd1);
    chk("same_valid", 32'(d_out_valid), 32'd0);
    chk("same_count", 32'(d_count), 32'd1);

    // Backpressure holds the head line.
    idle(); do_reset(); step();
    alloc_n(1);
    fill(0, 8'h55); step();
    d_fill_en = 1'b0;
    repeat (3) begin
      settle();
      chk("bp_valid", 32'(d_out_valid), 32'd1);
      chk("bp_data",  32'(d_out_data), 32'h55);
      chk("bp_count", 32'(d_count), 32'd1);
      step();
    end
    sb.push_back('{0, 8'h55});
    d_out_ready = 1'b1;
    step();
    settle();
    chk("bp_empty", 32'(d_empty), 32'd1);

    // Reset in the middle of traffic.
    idle(); do_reset(); step();
    alloc_n(3);
    fill(0, 8'h01); step();
    fill(1, 8'h02); step();
    fill(3, 8'h03); step();
    idle(); settle();
    chk("mid_pre_err",   32'(d_fill_err), 32'd1);
    chk("mid_pre_count", 32'(d_count), 32'd3);
    chk("mid_pre_valid", 32'(d_out_valid), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_valid",    32'(d_out_valid), 32'd0);
    chk("mid_empty",    32'(d_empty), 32'd1);
    chk("mid_fill_err", 32'(d_fill_err), 32'd0);
    chk("mid_alloc_id", 32'(d_alloc_id), 32'd0);
    chk("mid_count",    32'(d_count), 32'd0);
    #1;
    reset = 1'b1;
    step();
    fill(0, 8'h99); step();
    idle(); settle();
    chk("stale_fill_err", 32'(d_fill_err), 32'd1);
    chk("stale_valid",    32'(d_out_valid), 32'd0);
    chk("dir_drained",    32'(sb.size()), 32'd0);

    // Default-size run with random fill order and random backpressure.
    idle(); do_reset(); step();
    tail2 = 0;
    for (int c = 0; c < 300; c++) begin
      int k;
      int id;
      logic exp_gnt;
      r_fill_en = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 9) < 6) begin
        k  = int'($urandom_range(0, pend.size() - 1));
        id = pend[k];
        pend.delete(k);
        mem2[id]    = rand_line();
        r_fill_en   = 1'b1;
        r_fill_id   = RIW'(id);
        r_fill_data = mem2[id];
      end
      r_alloc_req = ($urandom_range(0, 9) < 6);
      r_out_ready = ($urandom_range(0, 9) < 7);
      exp_gnt     = r_alloc_req && (sb2.size() < RBS);
      settle();
      chk("rand_gnt", 32'(r_alloc_gnt), 32'(exp_gnt));
      if (exp_gnt) begin
        chk("rand_alloc_id", 32'(r_alloc_id), 32'(tail2 % RBS));
        sb2.push_back(tail2 % RBS);
        pend.push_back(tail2 % RBS);
        tail2++;
      end
      step();
    end
    r_alloc_req = 1'b0;
    r_out_ready = 1'b1;
    for (int g = 0; g < 400 && sb2.size() > 0; g++) begin
      int id;
      r_fill_en = 1'b0;
      if (pend.size() > 0) begin
        id = pend.pop_back();
        mem2[id]    = rand_line();
        r_fill_en   = 1'b1;
        r_fill_id   = RIW'(id);
        r_fill_data = mem2[id];
      end
      step();
    end
    r_fill_en   = 1'b0;
    r_out_ready = 1'b0;
    settle();
    chk("rand_drained",  32'(sb2.size()), 32'd0);
    chk("rand_fill_err", 32'(r_fill_err), 32'd0);
    chk("rand_empty",    32'(r_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/read_reorder_buffer.md
READ_REORDER_BUFFER -- requirements
Module: read_reorder_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, line width in bits.
REQ-002 SHALL have parameter BUFFER_SIZE, default 128, entry count (power of 2, >=2); ID_WIDTH = $clog2(BUFFER_SIZE).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alloc_req  input  1  request a slot for a new outstanding DRAM read.
REQ-006 SHALL have port alloc_gnt  output  1  slot granted this cycle.
REQ-007 SHALL have port alloc_id  output  ID_WIDTH  slot index granted (tail).
REQ-008 SHALL have port fill_en  input  1  DRAM return data valid.
REQ-009 SHALL have port fill_id  input  ID_WIDTH  slot the returned line belongs to.
REQ-010 SHALL have port fill_data  input  DATA_WIDTH  returned line.
REQ-011 SHALL have port out_valid  output  1  in-order head line available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head line.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  head line.
REQ-014 SHALL have port out_id  output  ID_WIDTH  head slot index.
REQ-015 SHALL have port count  output  ID_WIDTH+1  allocated (not yet popped) entries.
REQ-016 SHALL have ports full, empty  output  1 each  count==BUFFER_SIZE / count==0.
REQ-017 SHALL have port fill_err  output  1  sticky illegal-fill flag.

Function
REQ-018 SHALL keep head and tail pointers of ID_WIDTH+1 bits, wrapping modulo 2*BUFFER_SIZE; slot index = low ID_WIDTH bits; count = tail-head.
REQ-019 SHALL drive alloc_gnt = alloc_req && !full combinationally and alloc_id = tail[ID_WIDTH-1:0]; on alloc_gnt, tail increments at the edge.
REQ-020 SHALL keep one filled bit per slot; a legal fill writes fill_data to the slot and sets its filled bit at the edge.
REQ-021 SHALL treat a fill as legal only if fill_id lies in the allocated window [head, tail) as registered before the edge and its filled bit is 0.
REQ-022 SHALL ignore an illegal fill (no write, no bit change) and set fill_err at the next edge; fill_err stays 1 until reset.
REQ-023 SHALL drive out_valid = !empty && filled[head slot], out_data = entry[head slot], out_id = head slot, all combinational from registered state (no fill-to-output bypass; fill-to-out_valid latency 1 cycle).
REQ-024 SHALL pop on out_valid && out_ready: clear filled[head slot], increment head at the edge.
REQ-025 SHALL present lines strictly in allocation order regardless of fill order; a filled non-head slot stays hidden until all earlier slots pop.
REQ-026 SHALL, when full with simultaneous pop and alloc_req, deny allocation (alloc_gnt=0) that cycle; grant follows the next cycle.
REQ-027 SHALL, when empty with simultaneous alloc and fill to the new id, flag that fill as illegal (slot not yet allocated).
REQ-028 SHALL allow alloc, fill and pop in the same cycle on distinct slots; count changes by +1, 0 or -1 accordingly.
REQ-029 SHALL hold out_valid and out_data stable while out_valid=1 and out_ready=0.
REQ-030 SHALL never require consumer ready before asserting out_valid.

Reset
REQ-031 SHALL on reset=0, asynchronously: head=0, tail=0, all filled bits 0, fill_err=0; hence count=0, empty=1, full=0, out_valid=0, alloc_id=0.
REQ-032 SHALL not reset the data array; out_data is don't-care while out_valid=0.
REQ-033 SHALL discard all outstanding allocations on reset mid-operation; post-reset fills to old ids are illegal.

Verification (BUFFER_SIZE=4, DATA_WIDTH=8 unless stated)
REQ-034 SHALL cover out-of-order return: alloc ids 0,1,2; fill 2=0xC2, 0=0xA0, 1=0xB1 on separate cycles, out_ready=1 -> pops 0xA0,0xB1,0xC2 in order, out_valid first 1 cycle after fill of id 0.
REQ-035 SHALL cover full: 4 allocs -> full=1, count=4, 5th alloc_req gives alloc_gnt=0; pop+alloc same cycle -> gnt=0, granted next cycle with alloc_id=0 (wrap).
REQ-036 SHALL cover illegal fills: fill id 3 with count=2 -> fill_err=1 next cycle, no data change; double fill of id 0 -> first data retained, fill_err=1.
REQ-037 SHALL cover backpressure: head filled 0x55, out_ready=0 for 3 cycles -> out_valid=1, out_data=0x55 stable, count unchanged.
REQ-038 SHALL cover reset mid-operation: count=3 with 2 filled, assert reset -> immediately out_valid=0, empty=1, fill_err=0, alloc_id=0.
REQ-039 SHALL cover wrap-around at defaults: 300 alloc/fill/pop cycles with random fill order and out_ready -> output sequence matches allocation order, no fill_err.
